// File: rtl/tfrcoalesce.sv
// rtl/tfrcoalesce.sv - latest-value-wins coalescing source for the slow value-transfer CDC stage
module tfrcoalesce #(
    parameter int             W       = 32,
    parameter logic [W-1:0]   DEFAULT = '0,
    parameter int             REFRESH = 0,
    parameter int             LGREF   = 16,
    parameter int             DW      = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid,
    input  logic [W-1:0]  i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [W-1:0]  o_data,
    output logic          o_pending,
    output logic [DW-1:0] o_dropped
);

    localparam logic [LGREF-1:0] REF_LAST = (REFRESH > 0) ? LGREF'(REFRESH - 1) : '0;

    logic             r_valid;
    logic [W-1:0]     r_data;
    logic             r_pending;
    logic [W-1:0]     r_pdata;
    logic [DW-1:0]    r_dropped;
    logic [LGREF-1:0] r_timer;

    logic w_free;
    logic w_fire;
    logic w_drop;

    assign w_free = !r_valid || i_ready;
    // Refresh only re-presents the current value when the slot is idle and nothing newer exists.
    assign w_fire = (REFRESH > 0) && !r_valid && !r_pending && !i_valid && (r_timer == REF_LAST);
    // A queued value is discarded whenever a newer input arrives, whether it supersedes in place or replaces it in the queue.
    assign w_drop = i_valid && r_pending;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid   <= 1'b0;
            r_data    <= DEFAULT;
            r_pending <= 1'b0;
            r_pdata   <= '0;
            r_dropped <= '0;
        end else begin
            if (w_free) begin
                if (i_valid) begin
                    r_data    <= i_data;
                    r_valid   <= 1'b1;
                    r_pending <= 1'b0;
                end else if (r_pending) begin
                    r_data    <= r_pdata;
                    r_valid   <= 1'b1;
                    r_pending <= 1'b0;
                end else if (w_fire) begin
                    r_valid   <= 1'b1;
                end else begin
                    r_valid   <= 1'b0;
                end
            end else if (i_valid) begin
                r_pdata   <= i_data;
                r_pending <= 1'b1;
            end
            if (w_drop && (r_dropped != {DW{1'b1}})) begin
                r_dropped <= r_dropped + DW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || (REFRESH == 0)) begin
            r_timer <= '0;
        end else if (i_valid || (r_valid && i_ready) || w_fire) begin
            r_timer <= '0;
        end else if (!r_valid && !r_pending) begin
            r_timer <= r_timer + LGREF'(1);
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_pending = r_pending;
    assign o_dropped = r_dropped;

endmodule

// File: tb/tb_tfrcoalesce.sv
// tb/tb_tfrcoalesce.sv - directed bench for tfrcoalesce (refresh/saturating instance plus a plain instance)
module tb_tfrcoalesce;

    localparam logic [31:0] DEF = 32'hD0D0_0001;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_ready = 1'b0;

    logic        o_valid, n_valid;
    logic [31:0] o_data, n_data;
    logic        o_pending, n_pending;
    logic [1:0]  o_dropped;
    logic [7:0]  n_dropped;

    int vectors = 0;
    int miscompares = 0;

    always #5 i_clk = ~i_clk;

    tfrcoalesce #(.W(32), .DEFAULT(DEF), .REFRESH(4), .LGREF(16), .DW(2)) u_dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_pending(o_pending), .o_dropped(o_dropped)
    );

    tfrcoalesce #(.W(32), .DEFAULT(32'h0), .REFRESH(0), .LGREF(16), .DW(8)) u_nr (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
        .o_valid(n_valid), .i_ready(i_ready), .o_data(n_data),
        .o_pending(n_pending), .o_dropped(n_dropped)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        i_valid = v;
        i_data  = d;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        drive(1'b0, '0);
        i_ready = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    // Per-cycle protocol monitor on the refresh instance.
    always @(posedge i_clk) begin
        logic        pv, pr, prst;
        logic [31:0] pd;
        pv = o_valid; pr = i_ready; prst = i_reset; pd = o_data;
        #1;
        if (prst) begin
            check("mon_reset_valid", o_valid, 1'b0);
        end else if (pv && !pr) begin
            check("mon_stall_valid", o_valid, 1'b1);
            check("mon_stall_data", o_data, pd);
        end
    end

    initial begin
        do_reset();
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, DEF);
        check("rst_pending", o_pending, 0);
        check("rst_dropped", o_dropped, 0);

        // Single value with the sink always ready.
        i_ready = 1'b1;
        drive(1'b1, 32'h11); tick();
        check("single_valid", o_valid, 1);
        check("single_data", o_data, 32'h11);
        drive(1'b0, '0); tick();
        check("single_idle", o_valid, 0);
        check("single_hold", o_data, 32'h11);

        // Stall: three values, the middle one is discarded.
        do_reset();
        drive(1'b1, 32'h1); tick();
        check("stall_d1", o_data, 32'h1);
        check("stall_p1", o_pending, 0);
        drive(1'b1, 32'h2); tick();
        check("stall_p2", o_pending, 1);
        drive(1'b1, 32'h3); tick();
        check("stall_d3", o_data, 32'h1);
        check("stall_drop", o_dropped, 1);
        check("stall_drop_nr", n_dropped, 1);
        drive(1'b0, '0); tick();
        check("stall_held", o_data, 32'h1);
        i_ready = 1'b1; tick();
        check("stall_send3", o_data, 32'h3);
        check("stall_send3_v", o_valid, 1);
        check("stall_send3_p", o_pending, 0);
        tick();
        check("stall_done", o_valid, 0);

        // Same-cycle supersede of a queued value.
        do_reset();
        drive(1'b1, 32'h9); tick();
        drive(1'b1, 32'hA); tick();
        check("sup_pend", o_pending, 1);
        i_ready = 1'b1;
        drive(1'b1, 32'hB); tick();
        check("sup_data", o_data, 32'hB);
        check("sup_pend0", o_pending, 0);
        check("sup_drop", o_dropped, 1);
        drive(1'b0, '0); tick();
        check("sup_idle", o_valid, 0);

        // Refresh of DEFAULT before any real data, held under stall.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("refdef_quiet", o_valid, 0);
        end
        tick();
        check("refdef_valid", o_valid, 1);
        check("refdef_data", o_data, DEF);
        check("refdef_nr", n_valid, 0);
        tick();
        check("refdef_stall", o_valid, 1);

        // Refresh after a handshake, then i_valid on the fire cycle.
        do_reset();
        i_ready = 1'b1;
        drive(1'b1, 32'h55); tick();
        check("ref_first", o_valid, 1);
        drive(1'b0, '0); tick();
        check("ref_hs", o_valid, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ref_quiet", o_valid, 0);
        end
        tick();
        check("ref_fire", o_valid, 1);
        check("ref_fire_data", o_data, 32'h55);
        check("ref_nr", n_valid, 0);
        tick();
        check("ref_hs2", o_valid, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ref_quiet2", o_valid, 0);
        end
        drive(1'b1, 32'h66); tick();
        check("ref_new_valid", o_valid, 1);
        check("ref_new_data", o_data, 32'h66);
        drive(1'b0, '0); tick();
        check("ref_new_hs", o_valid, 0);
        tick();
        check("ref_no_extra", o_valid, 0);

        // Saturation: seven values into a stalled slot give five drops.
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            drive(1'b1, 32'(k) + 32'h20); tick();
        end
        drive(1'b0, '0);
        check("sat_dut", o_dropped, 2'b11);
        check("sat_nr", n_dropped, 5);
        check("sat_head", o_data, 32'h21);
        i_ready = 1'b1; tick();
        check("sat_last", o_data, 32'h27);

        // Reset during a stall with a queued value.
        do_reset();
        drive(1'b1, 32'h71); tick();
        drive(1'b1, 32'h72); tick();
        check("rs_pre_v", o_valid, 1);
        check("rs_pre_p", o_pending, 1);
        i_reset = 1'b1; drive(1'b0, '0); tick();
        check("rs_valid", o_valid, 0);
        check("rs_pend", o_pending, 0);
        check("rs_data", o_data, DEF);
        check("rs_drop", o_dropped, 0);
        i_reset = 1'b0; tick();
        check("rs_after", o_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
